fetch_ctrl: RTL

Instruction-fetch sequencer for the MIPS core. Owns the program counter, issues word fetches to instruction memory over a req/ack handshake, and hands each fetched word to decode over a valid/ready handshake. Handles start, stall, branch/jump redirect and a halt word. Sits between the PC/imem side of the datapath and the decode stage.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/pc_reg.sv | 40 ++++
 rtl/fetch_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front end.
// The fetch FSM encoding is fixed so that the state can be probed from legacy tooling.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,
    FS_FETCH   = 2'd1,
    FS_DELIVER = 2'd2,
    FS_HALTED  = 2'd3
  } fetch_state_t;

  // Instruction fetches are word aligned; the two low address bits never reach memory.
  function automatic logic [31:0] word_align32(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: async reset to RESET_PC, parallel load, increment by STEP.
// Load wins over increment so a redirect can never be lost to a same-cycle ack.
module pc_reg #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] STEP     = WIDTH'(4)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] pc_o
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + STEP;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches words over req/ack and
// hands them to decode over valid/ready, with redirect, stall and halt handling.
module fetch_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned        WIDTH     = 32,
  parameter logic [WIDTH-1:0]   RESET_PC  = '0,
  parameter int unsigned        STEP      = 4,
  parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [WIDTH-1:0]   redirect_pc,
  output logic               imem_req,
  output logic [WIDTH-1:0]   imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [WIDTH-1:0]   instr_pc,
  input  logic               instr_ready,
  output logic               busy,
  output logic               halted
);

  fetch_state_t state_q, state_d;

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [WIDTH-1:0]   instr_pc_q, instr_pc_d;
  logic [WIDTH-1:0]   pc;

  logic st_idle, st_fetch, st_deliver, st_halted;
  logic redirect_take, start_take, ack_take, accept, accept_halt;
  logic pc_load, pc_inc;
  logic [WIDTH-1:0] pc_load_val;
  logic [WIDTH-1:0] redirect_target;
  logic redirect_lsb_unused;

  assign st_idle    = (state_q == FS_IDLE);
  assign st_fetch   = (state_q == FS_FETCH);
  assign st_deliver = (state_q == FS_DELIVER);
  assign st_halted  = (state_q == FS_HALTED);

  assign redirect_target     = {redirect_pc[WIDTH-1:2], 2'b00};
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  // Redirect outranks stall; stall outranks a normal ack or acceptance.
  assign redirect_take = redirect_valid & (st_fetch | st_deliver);
  assign start_take    = start & (st_idle | st_halted);
  assign ack_take      = st_fetch & imem_ack & ~stall & ~redirect_valid;
  assign accept        = st_deliver & instr_ready & ~stall & ~redirect_valid;
  assign accept_halt   = accept & (instr_q == HALT_WORD);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FS_IDLE: begin
        if (start_take) state_d = FS_FETCH;
      end
      FS_FETCH: begin
        if (redirect_take)  state_d = FS_FETCH;
        else if (ack_take)  state_d = FS_DELIVER;
      end
      FS_DELIVER: begin
        if (redirect_take)     state_d = FS_FETCH;
        else if (accept_halt)  state_d = FS_HALTED;
        else if (accept)       state_d = FS_FETCH;
      end
      FS_HALTED: begin
        if (start_take) state_d = FS_FETCH;
      end
      default: state_d = FS_IDLE;
    endcase
  end

  always_comb begin
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    if (ack_take) begin
      instr_d    = imem_rdata;
      instr_pc_d = pc;
    end
  end

  assign pc_load     = redirect_take | start_take;
  assign pc_load_val = redirect_take ? redirect_target : RESET_PC;
  assign pc_inc      = ack_take;

  pc_reg #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC),
    .STEP     (WIDTH'(STEP))
  ) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (pc_load),
    .load_val_i (pc_load_val),
    .inc_i      (pc_inc),
    .pc_o       (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FS_IDLE;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign imem_req    = st_fetch & ~stall;
  assign imem_addr   = pc;
  assign instr_valid = st_deliver;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign busy        = st_fetch | st_deliver;
  assign halted      = st_halted;

endmodule
